// File: rtl/plru_update_unit_pkg.sv
// Shared types and constants for the 4-way tree-PLRU replacement front end.
package plru_update_unit_pkg;

    localparam int PLRU_WIDTH = 3;
    localparam int NUM_WAYS   = 4;

    typedef logic [PLRU_WIDTH-1:0]        plru_bits_t;
    typedef logic [$clog2(NUM_WAYS)-1:0]  way_t;

endpackage

// File: rtl/plru_update_unit_if.sv
// Request/response handshake bundle between the cache pipeline and the PLRU update unit.
interface plru_update_unit_if
    import plru_update_unit_pkg::*;
#(
    parameter int S_INDEX = 4
);

    logic               req_valid;
    logic               req_ready;
    logic [S_INDEX-1:0] req_set;
    logic               req_hit;
    way_t               req_way;
    logic               resp_valid;
    logic               resp_ready;
    way_t               resp_way;
    logic [S_INDEX-1:0] resp_set;

    modport master (
        output req_valid, req_set, req_hit, req_way, resp_ready,
        input  req_ready, resp_valid, resp_way, resp_set
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_way, resp_ready,
        output req_ready, resp_valid, resp_way, resp_set
    );

endinterface

// File: rtl/plru_update_unit_plru_tree4.sv
// Combinational 4-way tree-PLRU: victim selection and post-access state update.
module plru_tree4
    import plru_update_unit_pkg::*;
(
    input  plru_bits_t bits,
    input  way_t       way,
    output way_t       victim,
    output plru_bits_t new_bits
);

    // Root bit picks the pair, the pair bit picks the way inside it.
    always_comb begin
        victim = bits[0] ? (bits[2] ? 2'd3 : 2'd2) : (bits[1] ? 2'd1 : 2'd0);
    end

    // Point every tree node on the used way's path away from it; the other pair bit is kept.
    always_comb begin
        new_bits = bits;
        if (way[1]) begin
            new_bits[0] = 1'b0;
            new_bits[2] = (way == 2'd2);
        end else begin
            new_bits[0] = 1'b1;
            new_bits[1] = (way == 2'd0);
        end
    end

endmodule

// File: rtl/plru_update_unit.sv
// Two-stage tree-PLRU update unit with last-write bypass. Optional statistics
// counters are enabled by defining PLRU_STATS_EN.
module plru_update_unit
    import plru_update_unit_pkg::*;
#(
    parameter int S_INDEX = 4
`ifdef PLRU_STATS_EN
    , parameter int CNT_WIDTH = 32
`endif
)
(
    input  logic               clk,
    input  logic               rst,
    plru_update_unit_if.slave  bus,
    output logic               lru_csb0,
    output logic               lru_web0,
    output logic [S_INDEX-1:0] lru_addr0,
    input  plru_bits_t         lru_dout0,
    output logic               lru_csb1,
    output logic               lru_web1,
    output logic [S_INDEX-1:0] lru_addr1,
    output plru_bits_t         lru_din1
`ifdef PLRU_STATS_EN
    , output logic [CNT_WIDTH-1:0] hit_count
    , output logic [CNT_WIDTH-1:0] miss_count
`endif
);

    logic               s1_valid;
    logic [S_INDEX-1:0] s1_set;
    logic               s1_hit;
    way_t               s1_way;
    logic               byp_valid;
    logic [S_INDEX-1:0] byp_set;
    plru_bits_t         byp_bits;

    logic               accept;
    logic               fire;
    plru_bits_t         cur_bits;
    plru_bits_t         new_bits;
    way_t               victim;
    way_t               use_way;

    assign bus.req_ready = !s1_valid || bus.resp_ready;
    // No array read may be launched while reset is held, even if a request is presented.
    assign accept        = bus.req_valid && bus.req_ready && !rst;
    assign fire          = s1_valid && bus.resp_ready;

    // The previous write lands in the array on the same edge this read samples, so prefer the bypass copy.
    assign cur_bits = (byp_valid && (byp_set == s1_set)) ? byp_bits : lru_dout0;
    assign use_way  = s1_hit ? s1_way : victim;

    plru_tree4 u_tree (
        .bits     (cur_bits),
        .way      (use_way),
        .victim   (victim),
        .new_bits (new_bits)
    );

    assign bus.resp_valid = s1_valid;
    assign bus.resp_way   = s1_valid ? use_way : 2'd0;
    assign bus.resp_set   = s1_set;

    assign lru_csb0  = !accept;
    assign lru_web0  = 1'b1;
    assign lru_addr0 = accept ? bus.req_set : {S_INDEX{1'b0}};
    assign lru_csb1  = !fire;
    assign lru_web1  = !fire;
    assign lru_addr1 = fire ? s1_set : {S_INDEX{1'b0}};
    assign lru_din1  = fire ? new_bits : 3'b000;

    // S1 request register: loads on accept, empties when the response leaves without a follower.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_set   <= {S_INDEX{1'b0}};
            s1_hit   <= 1'b0;
            s1_way   <= 2'd0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_set   <= bus.req_set;
            s1_hit   <= bus.req_hit;
            s1_way   <= bus.req_way;
        end else if (fire) begin
            s1_valid <= 1'b0;
        end
    end

    // Bypass register mirrors the most recent array write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_valid <= 1'b0;
            byp_set   <= {S_INDEX{1'b0}};
            byp_bits  <= 3'b000;
        end else if (fire) begin
            byp_valid <= 1'b1;
            byp_set   <= s1_set;
            byp_bits  <= new_bits;
        end
    end

`ifdef PLRU_STATS_EN
    // Saturating hit/miss counters, stepped once per delivered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= {CNT_WIDTH{1'b0}};
            miss_count <= {CNT_WIDTH{1'b0}};
        end else if (fire) begin
            if (s1_hit) begin
                if (hit_count != {CNT_WIDTH{1'b1}}) begin
                    hit_count <= hit_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                if (miss_count != {CNT_WIDTH{1'b1}}) begin
                    miss_count <= miss_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_plru_update_unit.sv
// Self-checking bench for plru_update_unit: directed scenarios followed by random traffic,
// checked against a per-set "which half / which way is older" model.
module tb_plru_update_unit;
    import plru_update_unit_pkg::*;

    localparam int S_INDEX  = 4;
    localparam int NUM_SETS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plru_update_unit_if #(.S_INDEX(S_INDEX)) bus ();

    logic               lru_csb0, lru_web0, lru_csb1, lru_web1;
    logic [S_INDEX-1:0] lru_addr0, lru_addr1;
    plru_bits_t         lru_dout0, lru_din1;
    plru_bits_t         mem [NUM_SETS];
`ifdef PLRU_STATS_EN
    logic [31:0]        hit_count, miss_count;
`endif

    plru_update_unit #(.S_INDEX(S_INDEX)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .lru_csb0  (lru_csb0),
        .lru_web0  (lru_web0),
        .lru_addr0 (lru_addr0),
        .lru_dout0 (lru_dout0),
        .lru_csb1  (lru_csb1),
        .lru_web1  (lru_web1),
        .lru_addr1 (lru_addr1),
        .lru_din1  (lru_din1)
`ifdef PLRU_STATS_EN
        , .hit_count  (hit_count)
        , .miss_count (miss_count)
`endif
    );

    // Dual-port state array: read-before-write, reset by the same rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) mem[i] <= 3'b000;
            lru_dout0 <= 3'b000;
        end else begin
            if (!lru_csb0 && lru_web0) lru_dout0 <= mem[lru_addr0];
            if (!lru_csb1 && !lru_web1) mem[lru_addr1] <= lru_din1;
        end
    end

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int writes_exp = 0;

    always @(posedge clk) begin
        if (!rst && !lru_csb1 && !lru_web1) writes_seen <= writes_seen + 1;
    end

    // Reference model: per set, which half is older and which way of each pair is older.
    int root_half [NUM_SETS];
    int pair_victim [NUM_SETS][2];
    bit e_valid;
    int e_set, e_way;
    bit e_hit;
    int exp_hits, exp_misses;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_SETS; i++) begin
            root_half[i]      = 0;
            pair_victim[i][0] = 0;
            pair_victim[i][1] = 2;
        end
        e_valid    = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    function automatic int model_victim(input int s);
        return pair_victim[s][root_half[s]];
    endfunction

    function automatic logic [2:0] model_bits(input int s);
        return {pair_victim[s][1] == 3, pair_victim[s][0] == 1, root_half[s] == 1};
    endfunction

    task automatic model_use(input int s, input int w);
        root_half[s]          = (w < 2) ? 1 : 0;
        pair_victim[s][w / 2] = w ^ 1;
    endtask

    // One clock cycle: drive at posedge+1, check mid-cycle, advance the model at the edge.
    task automatic step(input bit v, input int s, input bit h, input int w, input bit rr);
        bit acc, fire;
        int ew;
        bus.req_valid  = v;
        bus.req_set    = s[3:0];
        bus.req_hit    = h;
        bus.req_way    = w[1:0];
        bus.resp_ready = rr;
        #3;
        acc  = v && (!e_valid || rr);
        fire = e_valid && rr;
        ew   = 0;
        chk("req_ready", bus.req_ready, !e_valid || rr);
        chk("resp_valid", bus.resp_valid, e_valid);
        chk("csb0", lru_csb0, !acc);
        if (acc) chk("addr0", lru_addr0, s);
        chk("csb1", lru_csb1, !fire);
        chk("web1", lru_web1, !fire);
        if (e_valid) begin
            ew = e_hit ? e_way : model_victim(e_set);
            chk("resp_way", bus.resp_way, ew);
            chk("resp_set", bus.resp_set, e_set);
        end
        if (fire) begin
            model_use(e_set, ew);
            chk("addr1", lru_addr1, e_set);
            chk("din1", lru_din1, model_bits(e_set));
            writes_exp++;
            if (e_hit) exp_hits++; else exp_misses++;
        end
        @(posedge clk);
        if (acc) begin
            e_valid = 1'b1; e_set = s; e_hit = h; e_way = w;
        end else if (fire) begin
            e_valid = 1'b0;
        end
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_way", bus.resp_way, 0);
        chk("rst_resp_set", bus.resp_set, 0);
        chk("rst_csb0", lru_csb0, 1);
        chk("rst_csb1", lru_csb1, 1);
        chk("rst_web1", lru_web1, 1);
        chk("rst_addr0", lru_addr0, 0);
        chk("rst_addr1", lru_addr1, 0);
        chk("rst_din1", lru_din1, 0);
`ifdef PLRU_STATS_EN
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_set = 4'd0; bus.req_hit = 1'b0;
        bus.req_way = 2'd0; bus.resp_ready = 1'b0;
        model_reset();
        #12;
        chk_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Same-set misses back to back, then a hit and a miss on set 3.
        step(1'b1, 5, 1'b0, 0, 1'b1);
        step(1'b1, 5, 1'b0, 0, 1'b1);
        step(1'b1, 3, 1'b1, 3, 1'b1);
        step(1'b1, 3, 1'b0, 0, 1'b1);
        step(1'b1, 9, 1'b0, 0, 1'b1);
        // Three-cycle stall with a competing request presented.
        for (int i = 0; i < 3; i++) step(1'b1, 4, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        // Alternating sets with no bubbles.
        step(1'b1, 1, 1'b0, 0, 1'b1);
        step(1'b1, 2, 1'b0, 0, 1'b1);
        step(1'b1, 1, 1'b0, 0, 1'b1);
        step(1'b1, 2, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // Random traffic over a few sets to force bypass hits and stalls.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3), $urandom_range(0, 3) != 0);
        end
        step(1'b0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        chk("write_count", writes_seen, writes_exp);
`ifdef PLRU_STATS_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
`endif

        // Reset while S1 holds a request that would otherwise fire.
        step(1'b1, 7, 1'b0, 0, 1'b1);
        step(1'b1, 7, 1'b0, 0, 1'b1);
        bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b1, 7, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        chk("write_count_after_rst", writes_seen, writes_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
